// File: rtl/ntt_mem_pkg.sv
// Shared definitions for the N-bank coefficient memory and its read sequencer.
// Provides the default geometry (lanes, address and word width), word/address/row
// types, and the encoding of the bank_row_reader state machine.
package ntt_mem_pkg;

    localparam int NTT_N  = 257;
    localparam int NTT_AW = 8;
    localparam int NTT_DW = 32;

    typedef logic [NTT_DW-1:0] word_t;
    typedef logic [NTT_AW-1:0] addr_t;
    typedef word_t [NTT_N-1:0] row_t;

    // Reader FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/bank_row_reader_if.sv
// Valid/ready row stream carrying one N-lane row per beat.
//   data  : N*DW  row payload, lane k in bits [k*DW +: DW]
//   valid : 1     payload valid (driven by master)
//   ready : 1     sink accepts (driven by slave)
interface bank_row_reader_if
    import ntt_mem_pkg::*;
#(
    parameter int N  = NTT_N,
    parameter int DW = NTT_DW
) ();

    logic [N*DW-1:0] data;
    logic            valid;
    logic            ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/bank_row_reader_row_fifo.sv
// row_fifo: synchronous first-word-fall-through FIFO for whole memory rows.
//   clk, rst_n : clock, asynchronous active-low reset (pointers and count only)
//   push       : write push_data this cycle (caller guarantees not full)
//   push_data  : W-bit row to store
//   pop        : consume the head entry (ignored when empty)
//   pop_data   : head entry, valid whenever empty is low
//   full/empty : occupancy flags
//   count      : number of stored entries, 0..DEPTH
module row_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop   = pop && !empty;
    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Row storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bank_row_reader.sv
// bank_row_reader: read-side sequencer for the N-bank coefficient memory.
// On start it issues one row address per cycle to all banks, tracks reads in
// flight through the fixed BRAM latency, and parks returned rows in an output
// FIFO that is credit-protected so downstream back-pressure never drops data.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : command pulse, sampled only when idle
//   base_addr  : first row address
//   row_count  : rows to read, 0..2**AW
//   busy       : high from accepted start until done
//   done       : one-cycle pulse after the last row is accepted
//   addr_read  : read address, same value on every lane
//   mem_dout   : bank read data, RD_LAT cycles after addr_read
//   m          : output row stream (master)
module bank_row_reader
    import ntt_mem_pkg::*;
#(
    parameter int N          = NTT_N,
    parameter int AW         = NTT_AW,
    parameter int DW         = NTT_DW,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [AW-1:0]      base_addr,
    input  logic [AW:0]        row_count,
    output logic               busy,
    output logic               done,
    output logic [N*AW-1:0]    addr_read,
    input  logic [N*DW-1:0]    mem_dout,
    bank_row_reader_if.master  m
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int OW = CW + 1;

    logic [1:0]        state;
    logic [AW-1:0]     cur_addr;
    logic [AW-1:0]     addr_hold;
    logic [AW-1:0]     addr_now;
    logic [AW:0]       remaining;
    logic [RD_LAT-1:0] vld_p;
    logic              zero_done;

    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              issue;
    logic              drain_done;
    logic [OW-1:0]     inflight;
    logic [OW-1:0]     occupancy;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++)
            inflight = inflight + OW'(vld_p[i]);
    end

    assign pop = !fifo_empty && m.ready;

    // A row leaving this cycle frees its slot before any read issued now can
    // land, so it is credited back immediately; without that, RD_LAT+1 deep
    // FIFOs could not sustain one row per cycle.
    assign occupancy  = OW'(fifo_count) + inflight - OW'(pop);
    assign issue      = (state == ST_ISSUE) && (occupancy < OW'(FIFO_DEPTH));
    assign drain_done = (state == ST_DRAIN) && (inflight == '0) && fifo_empty;

    assign addr_now  = issue ? cur_addr : addr_hold;
    assign addr_read = {N{addr_now}};
    assign busy      = (state != ST_IDLE) && !drain_done;
    assign done      = drain_done || zero_done;

    // Stage p0: address issue, FSM and row bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cur_addr  <= '0;
            addr_hold <= '0;
            remaining <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= (state == ST_IDLE) && start && (row_count == '0);
            case (state)
                ST_IDLE: begin
                    if (start && (row_count != '0)) begin
                        cur_addr  <= base_addr;
                        remaining <= row_count;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (issue) begin
                        cur_addr  <= cur_addr + 1'b1;
                        addr_hold <= cur_addr;
                        remaining <= remaining - 1'b1;
                        if (remaining == (AW+1)'(1))
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p1..pRD_LAT: read-valid pipe mirroring the BRAM latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= issue;
            for (int i = 1; i < RD_LAT; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    assign push = vld_p[RD_LAT-1];

    // Output stage: FWFT row buffer
    row_fifo #(
        .W     (N*DW),
        .DEPTH (FIFO_DEPTH)
    ) u_row_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem_dout),
        .pop       (pop),
        .pop_data  (m.data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign m.valid = !fifo_empty;

    // Credits must make a write into a full FIFO impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule

// File: tb/tb_bank_row_reader.sv
// Directed bench for bank_row_reader: instance A (RD_LAT=1, FIFO_DEPTH=4) covers
// the command, wrap, back-pressure, zero-count and reset scenarios; instance B
// (RD_LAT=2, FIFO_DEPTH=3) reads a full bank at full rate. Each lane is backed
// by a BRAM model whose content is a fixed function of (lane, row).
module tb_bank_row_reader;

    localparam int N  = 257;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            start_a, start_b;
    logic [AW-1:0]   base_a, base_b;
    logic [AW:0]     count_a, count_b;
    logic            busy_a, busy_b, done_a, done_b;
    logic [N*AW-1:0] addr_a, addr_b;
    logic [N*DW-1:0] dout_a, dout_b;

    bank_row_reader_if #(.N(N), .DW(DW)) mif_a ();
    bank_row_reader_if #(.N(N), .DW(DW)) mif_b ();

    bank_row_reader #(.N(N), .AW(AW), .DW(DW), .RD_LAT(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .base_addr(base_a), .row_count(count_a),
        .busy(busy_a), .done(done_a), .addr_read(addr_a), .mem_dout(dout_a), .m(mif_a)
    );

    bank_row_reader #(.N(N), .AW(AW), .DW(DW), .RD_LAT(2), .FIFO_DEPTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .base_addr(base_b), .row_count(count_b),
        .busy(busy_b), .done(done_b), .addr_read(addr_b), .mem_dout(dout_b), .m(mif_b)
    );

    function automatic logic [31:0] mem_word(input int k, input int r);
        return {4'hA, k[11:0], 8'h00, r[7:0]};
    endfunction

    logic [DW-1:0] q_a [N];
    logic [DW-1:0] s_b [N];
    logic [DW-1:0] q_b [N];
    for (genvar k = 0; k < N; k++) begin : g_bram
        always @(posedge clk) begin
            q_a[k] <= mem_word(k, int'(addr_a[k*AW +: AW]));
            s_b[k] <= mem_word(k, int'(addr_b[k*AW +: AW]));
            q_b[k] <= s_b[k];
        end
        assign dout_a[k*DW +: DW] = q_a[k];
        assign dout_b[k*DW +: DW] = q_b[k];
    end

    int errors = 0;
    int checks = 0;

    // Observations gathered by run_rows_a
    int r_got, r_bad, r_first_valid, r_last_hs, r_done_cyc, r_done_pulses;
    int r_stall_bad, r_addr_bad, bad_row, bad_lane;
    logic r_busy0, r_busy_at_done;
    logic [DW-1:0] bad_act, bad_exp;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives m_ready on instance A and records what comes out; cycle 0 is the
    // cycle right after the edge that sampled start.
    task automatic run_rows_a(input int base, input int count, input int mode);
        logic [15:0]     pat;
        logic [N*DW-1:0] prev_data;
        logic            prev_stall;
        logic            row_ok;
        logic [DW-1:0]   w_exp;
        int              cyc;
        int              r_exp;
        pat = 16'b1001_1011_0100_1101;
        prev_data = '0;
        prev_stall = 1'b0;
        cyc = 0;
        r_got = 0; r_bad = 0; r_first_valid = -1; r_last_hs = -100; r_done_cyc = -1;
        r_done_pulses = 0; r_stall_bad = 0; r_addr_bad = 0; r_busy0 = 1'b0; r_busy_at_done = 1'bx;
        while (cyc < count * 4 + 40) begin
            ready_set(mode == 0 ? 1'b1 : pat[cyc % 16]);
            if (cyc == 0) r_busy0 = busy_a;
            if (done_a === 1'b1) begin
                r_done_pulses++;
                r_done_cyc = cyc;
                r_busy_at_done = busy_a;
            end
            for (int k = 1; k < N; k++)
                if (addr_a[k*AW +: AW] !== addr_a[AW-1:0]) begin
                    r_addr_bad++;
                    break;
                end
            if (prev_stall && (mif_a.valid !== 1'b1 || mif_a.data !== prev_data)) r_stall_bad++;
            if (mif_a.valid === 1'b1) begin
                if (r_first_valid < 0) r_first_valid = cyc;
                if (mif_a.ready) begin
                    r_exp = (base + r_got) % 256;
                    row_ok = 1'b1;
                    for (int k = 0; k < N; k++) begin
                        w_exp = mem_word(k, r_exp);
                        if (row_ok && mif_a.data[k*DW +: DW] !== w_exp) begin
                            row_ok = 1'b0;
                            if (r_bad == 0) begin
                                bad_row = r_got; bad_lane = k;
                                bad_act = mif_a.data[k*DW +: DW]; bad_exp = w_exp;
                            end
                        end
                    end
                    if (!row_ok) r_bad++;
                    r_got++;
                    r_last_hs = cyc;
                end
            end
            prev_stall = (mif_a.valid === 1'b1) && !mif_a.ready;
            prev_data = mif_a.data;
            if (r_got >= count && cyc >= r_last_hs + 3) break;
            tick();
            cyc++;
        end
        ready_set(1'b1);
    endtask

    task automatic ready_set(input logic v);
        mif_a.ready = v;
    endtask

    task automatic start_a_cmd(input int base, input int count);
        base_a = AW'(base);
        count_a = (AW+1)'(count);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_a); end
        checks++; if (mif_a.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", mif_a.valid); end
        checks++; if (addr_a !== '0) begin errors++; $display("FAIL reset_addr lane0 got=%h want=00", addr_a[AW-1:0]); end
        checks++; if (busy_b !== 1'b0 || mif_b.valid !== 1'b0) begin errors++; $display("FAIL reset_b busy=%b valid=%b want 0/0", busy_b, mif_b.valid); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        start_a_cmd(0, 8);
        run_rows_a(0, 8, 0);
        checks++; if (r_busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", r_busy0); end
        checks++; if (r_first_valid !== 2) begin errors++; $display("FAIL basic_latency got=%0d want=2", r_first_valid); end
        checks++; if (r_got !== 8) begin errors++; $display("FAIL basic_rows got=%0d want=8", r_got); end
        checks++; if (r_bad !== 0) begin errors++; $display("FAIL basic_data bad_rows=%0d row=%0d lane=%0d got=%h want=%h", r_bad, bad_row, bad_lane, bad_act, bad_exp); end
        checks++; if (r_last_hs - r_first_valid !== 7) begin errors++; $display("FAIL basic_rate span=%0d want=7", r_last_hs - r_first_valid); end
        checks++; if (r_done_pulses !== 1 || r_done_cyc !== r_last_hs + 1) begin errors++; $display("FAIL basic_done pulses=%0d cyc=%0d want 1 at %0d", r_done_pulses, r_done_cyc, r_last_hs + 1); end
        checks++; if (r_busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got=%b want=0", r_busy_at_done); end
        checks++; if (r_addr_bad !== 0) begin errors++; $display("FAIL basic_lanes cycles=%0d want=0", r_addr_bad); end
    endtask

    task automatic test_wrap();
        start_a_cmd(252, 8);
        run_rows_a(252, 8, 0);
        checks++; if (r_got !== 8) begin errors++; $display("FAIL wrap_rows got=%0d want=8", r_got); end
        checks++; if (r_bad !== 0) begin errors++; $display("FAIL wrap_data bad_rows=%0d row=%0d lane=%0d got=%h want=%h", r_bad, bad_row, bad_lane, bad_act, bad_exp); end
        checks++; if (addr_a[AW-1:0] !== 8'd3) begin errors++; $display("FAIL wrap_addr_hold got=%0d want=3", addr_a[AW-1:0]); end
        checks++; if (r_done_pulses !== 1) begin errors++; $display("FAIL wrap_done pulses=%0d want=1", r_done_pulses); end
    endtask

    task automatic test_backpressure();
        start_a_cmd(40, 16);
        run_rows_a(40, 16, 1);
        checks++; if (r_got !== 16) begin errors++; $display("FAIL bp_rows got=%0d want=16", r_got); end
        checks++; if (r_bad !== 0) begin errors++; $display("FAIL bp_data bad_rows=%0d row=%0d lane=%0d got=%h want=%h", r_bad, bad_row, bad_lane, bad_act, bad_exp); end
        checks++; if (r_stall_bad !== 0) begin errors++; $display("FAIL bp_stable changes=%0d want=0", r_stall_bad); end
        checks++; if (r_done_pulses !== 1 || r_done_cyc !== r_last_hs + 1) begin errors++; $display("FAIL bp_done pulses=%0d cyc=%0d want 1 at %0d", r_done_pulses, r_done_cyc, r_last_hs + 1); end
        checks++; if (addr_a[AW-1:0] !== 8'd55) begin errors++; $display("FAIL bp_addr_hold got=%0d want=55", addr_a[AW-1:0]); end
    endtask

    task automatic test_zero_and_ignore();
        logic [AW-1:0] a0;
        int odd_cycles;
        int extra;
        a0 = addr_a[AW-1:0];
        start_a_cmd(77, 0);
        checks++; if (done_a !== 1'b1) begin errors++; $display("FAIL zero_done got=%b want=1", done_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b want=0", busy_a); end
        odd_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done_a !== 1'b0 || busy_a !== 1'b0 || mif_a.valid !== 1'b0 || addr_a[AW-1:0] !== a0) odd_cycles++;
        end
        checks++; if (odd_cycles !== 0) begin errors++; $display("FAIL zero_quiet cycles=%0d want=0", odd_cycles); end
        // Second start arrives while the count=4 run is busy and must be dropped.
        start_a_cmd(10, 4);
        base_a = 8'd100;
        count_a = 9'd8;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        run_rows_a(10, 4, 0);
        checks++; if (r_got !== 4) begin errors++; $display("FAIL ignore_rows got=%0d want=4", r_got); end
        checks++; if (r_bad !== 0) begin errors++; $display("FAIL ignore_data bad_rows=%0d row=%0d lane=%0d got=%h want=%h", r_bad, bad_row, bad_lane, bad_act, bad_exp); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (mif_a.valid !== 1'b0 || busy_a !== 1'b0) extra++;
            tick();
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_after cycles=%0d want=0", extra); end
    endtask

    task automatic test_reset_mid();
        int got;
        int extra;
        start_a_cmd(0, 10);
        got = 0;
        for (int i = 0; i < 40 && got < 4; i++) begin
            if (mif_a.valid === 1'b1) got++;
            tick();
        end
        checks++; if (got !== 4) begin errors++; $display("FAIL rstmid_pre rows=%0d want=4", got); end
        rst_n = 1'b0;
        #1;
        checks++; if (mif_a.valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL rstmid_clear valid=%b busy=%b done=%b want 0/0/0", mif_a.valid, busy_a, done_a); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        start_a_cmd(5, 2);
        run_rows_a(5, 2, 0);
        checks++; if (r_got !== 2) begin errors++; $display("FAIL rstmid_rows got=%0d want=2", r_got); end
        checks++; if (r_bad !== 0) begin errors++; $display("FAIL rstmid_data bad_rows=%0d row=%0d lane=%0d got=%h want=%h", r_bad, bad_row, bad_lane, bad_act, bad_exp); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            if (mif_a.valid !== 1'b0) extra++;
            tick();
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL rstmid_after cycles=%0d want=0", extra); end
    endtask

    task automatic test_full_bank();
        int got, bad, first, last, pulses, dcyc;
        logic row_ok;
        base_b = 8'd0;
        count_b = 9'd256;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        got = 0; bad = 0; first = -1; last = -100; pulses = 0; dcyc = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            mif_b.ready = 1'b1;
            if (done_b === 1'b1) begin pulses++; dcyc = cyc; end
            if (mif_b.valid === 1'b1) begin
                if (first < 0) first = cyc;
                row_ok = 1'b1;
                for (int k = 0; k < N; k++)
                    if (mif_b.data[k*DW +: DW] !== mem_word(k, got % 256)) row_ok = 1'b0;
                if (!row_ok) bad++;
                got++;
                last = cyc;
            end
            if (got >= 256 && cyc >= last + 3) break;
            tick();
        end
        checks++; if (got !== 256) begin errors++; $display("FAIL full_rows got=%0d want=256", got); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL full_data bad_rows=%0d want=0", bad); end
        checks++; if (first !== 3) begin errors++; $display("FAIL full_latency got=%0d want=3", first); end
        checks++; if (last - first !== 255) begin errors++; $display("FAIL full_rate span=%0d want=255", last - first); end
        checks++; if (pulses !== 1 || dcyc !== last + 1) begin errors++; $display("FAIL full_done pulses=%0d cyc=%0d want 1 at %0d", pulses, dcyc, last + 1); end
        checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL full_busy got=%b want=0", busy_b); end
    endtask

    initial begin
        rst_n = 1'b0;
        start_a = 1'b0; base_a = '0; count_a = '0;
        start_b = 1'b0; base_b = '0; count_b = '0;
        mif_a.ready = 1'b1;
        mif_b.ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_and_ignore();
        test_reset_mid();
        test_full_bank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
